// File: rtl/ad_emu.sv
// ADC serial-device emulator: serves generated sample words MSB-first on sdata, timed by the master's cs_n/sclk.
// Optional AD_EMU_NOISE_EN adds a 16-bit LFSR whose low 3 bits dither the loaded word.
module ad_emu #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LEAD_ZEROS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sclk,
  output logic              sdata,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_data,
  input  logic [DATA_W-1:0] ramp_step,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned N      = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W  = $clog2(N + 1);
  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
  logic                cs_prev, sclk_prev;
  logic [FILL_W-1:0]   fill_q;
  logic                armed_q;
  logic [N-1:0]        shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                alt_q, alt_d;
  logic [1:0]          fmode_q, fmode_d;
  logic [DATA_W-1:0]   fstep_q, fstep_d;
  logic                sdata_d, frame_done_d, err_short_d;
  logic [15:0]         frame_cnt_d;
  logic [DATA_W-1:0]   word_c;
  logic [N-1:0]        load_c;
  logic                cs_s, sclk_s, filled_c;
  logic                cs_fall_c, cs_rise_c, sclk_fall_c, last_c;

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign filled_c    = (fill_q == FILL_W'(SYNC_STAGES));
  // A fall only counts once cs_n has been seen high after reset, so a held-low cs_n is not a frame.
  assign cs_fall_c   = cs_prev & ~cs_s & armed_q;
  assign cs_rise_c   = ~cs_prev & cs_s;
  assign sclk_fall_c = sclk_prev & ~sclk_s;
  assign last_c      = (bit_cnt_q == CNT_W'(N - 1));

  // Synchronizers, edge-detect registers and post-reset arming.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      cs_sync   <= SYNC_STAGES'({cs_sync, cs_n});
      sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
      fill_q    <= filled_c ? fill_q : fill_q + FILL_W'(1);
      armed_q   <= armed_q | (filled_c & cs_s);
    end
  end

`ifdef AD_EMU_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // Frame word chosen at the cs_n fall.
  always_comb begin
    word_c = const_data;
    case (mode)
      2'b01:   word_c = acc_q;
      2'b10:   word_c = alt_q ? ~const_data : const_data;
      default: word_c = const_data;
    endcase
`ifdef AD_EMU_NOISE_EN
    word_c = word_c ^ DATA_W'(lfsr_q[2:0]);
`endif
    load_c = N'(word_c);
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sdata_d      = sdata;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;
    frame_cnt_d  = frame_cnt;
    acc_d        = acc_q;
    alt_d        = alt_q;
    fmode_d      = fmode_q;
    fstep_d      = fstep_q;
`ifdef AD_EMU_NOISE_EN
    lfsr_d       = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        sdata_d = 1'b0;
        if (cs_fall_c) begin
          shreg_d   = load_c;
          sdata_d   = load_c[N-1];
          bit_cnt_d = '0;
          fmode_d   = mode;
          fstep_d   = ramp_step;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Completion beats a simultaneous cs_n rise; the rise then skips TAIL.
        if (sclk_fall_c && last_c) begin
          sdata_d      = 1'b0;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt + 16'd1;
          if (fmode_q == 2'b01) acc_d = acc_q + fstep_q;
          if (fmode_q == 2'b10) alt_d = ~alt_q;
`ifdef AD_EMU_NOISE_EN
          lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
          state_d = cs_rise_c ? IDLE : TAIL;
        end else if (cs_rise_c) begin
          sdata_d     = 1'b0;
          err_short_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_fall_c) begin
          shreg_d   = {shreg_q[N-2:0], 1'b0};
          sdata_d   = shreg_q[N-2];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      TAIL: begin
        sdata_d = 1'b0;
        if (cs_rise_c) state_d = IDLE;
      end
      default: begin
        sdata_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= '0;
      alt_q      <= 1'b0;
      fmode_q    <= 2'b00;
      fstep_q    <= '0;
      sdata      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      frame_cnt  <= '0;
`ifdef AD_EMU_NOISE_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      alt_q      <= alt_d;
      fmode_q    <= fmode_d;
      fstep_q    <= fstep_d;
      sdata      <= sdata_d;
      busy       <= (state_d != IDLE);
      frame_done <= frame_done_d;
      err_short  <= err_short_d;
      frame_cnt  <= frame_cnt_d;
`ifdef AD_EMU_NOISE_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ad_emu.sv
// Self-checking bench for ad_emu: acts as the serial master and compares sampled words against a frame-level model.
module tb_ad_emu;

  localparam int N = 20;
  localparam int H = 6;

  logic        clk_sys = 1'b0;
  logic        rst_n, cs_n, sclk, sdata, busy, frame_done, err_short;
  logic [1:0]  mode;
  logic [15:0] const_data, ramp_step, frame_cnt;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0;

  logic [15:0] m_acc, m_cnt, m_lfsr;
  logic        m_alt;

  typedef struct {
    logic [1:0]  md;
    logic [15:0] cd;
    logic [15:0] st;
    int          nf;
    logic [15:0] w;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[11];

  ad_emu dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .sdata(sdata),
    .mode(mode), .const_data(const_data), .ramp_step(ramp_step), .busy(busy),
    .frame_done(frame_done), .err_short(err_short), .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (frame_done === 1'b1) done_cnt++;
    if (err_short === 1'b1) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic model_reset();
    m_acc = 16'h0; m_alt = 1'b0; m_cnt = 16'h0; m_lfsr = 16'hACE1;
  endtask

  function automatic logic [15:0] noise_bits();
`ifdef AD_EMU_NOISE_EN
    return {13'b0, m_lfsr[2:0]};
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] model_word(input logic [1:0] md, input logic [15:0] cd);
    logic [15:0] w;
    if (md == 2'b01) w = m_acc;
    else if (md == 2'b10) w = m_alt ? ~cd : cd;
    else w = cd;
    return w ^ noise_bits();
  endfunction

  task automatic model_done(input logic [1:0] md, input logic [15:0] st);
    m_cnt = m_cnt + 16'd1;
    if (md == 2'b01) m_acc = m_acc + st;
    if (md == 2'b10) m_alt = ~m_alt;
`ifdef AD_EMU_NOISE_EN
    m_lfsr = ((m_lfsr >> 1) | (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15));
`endif
  endtask

  // One master frame of nf sclk falls; a bit is sampled just before each fall.
  task automatic frame(input logic [1:0] md, input logic [15:0] cd, input logic [15:0] st,
                       input int nf, input bit use_exp, input logic [15:0] exp_w, input string name);
    logic [N-1:0] got, full;
    logic [15:0]  w;
    int d0, e0;
    mode = md; const_data = cd; ramp_step = st;
    wclk(2);
    w    = use_exp ? (exp_w ^ noise_bits()) : model_word(md, cd);
    full = {4'b0000, w};
    d0 = done_cnt; e0 = err_cnt; got = '0;
    cs_n = 1'b0;
    wclk(H);
    for (int i = 0; i < nf; i++) begin
      got = {got[N-2:0], sdata};
      sclk = 1'b0; wclk(H);
      sclk = 1'b1; wclk(H);
    end
    if (nf >= N) begin
      chk({name, " bits"}, 32'(got), 32'(full));
      chk({name, " done"}, 32'(done_cnt - d0), 32'd1);
      chk({name, " tail busy"}, 32'(busy), 32'd1);
      chk({name, " tail sdata"}, 32'(sdata), 32'd0);
      model_done(md, st);
      chk({name, " cnt"}, 32'(frame_cnt), 32'(m_cnt));
      cs_n = 1'b1; wclk(H);
      chk({name, " idle busy"}, 32'(busy), 32'd0);
      chk({name, " no err"}, 32'(err_cnt - e0), 32'd0);
    end else begin
      chk({name, " part bits"}, 32'(got), 32'(full >> (N - nf)));
      cs_n = 1'b1; wclk(H);
      chk({name, " err"}, 32'(err_cnt - e0), 32'd1);
      chk({name, " no done"}, 32'(done_cnt - d0), 32'd0);
      chk({name, " sdata"}, 32'(sdata), 32'd0);
      chk({name, " busy"}, 32'(busy), 32'd0);
      chk({name, " cnt"}, 32'(frame_cnt), 32'(m_cnt));
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 16'hA5C3, 16'h0000, 20, 16'hA5C3, 16'd1};
    tbl[1]  = '{2'b01, 16'h0000, 16'h4000, 20, 16'h0000, 16'd2};
    tbl[2]  = '{2'b01, 16'h0000, 16'h4000, 20, 16'h4000, 16'd3};
    tbl[3]  = '{2'b01, 16'h0000, 16'h4000, 20, 16'h8000, 16'd4};
    tbl[4]  = '{2'b01, 16'h0000, 16'h4000, 20, 16'hC000, 16'd5};
    tbl[5]  = '{2'b01, 16'h0000, 16'h4000, 20, 16'h0000, 16'd6};
    tbl[6]  = '{2'b10, 16'h00FF, 16'h0000, 20, 16'h00FF, 16'd7};
    tbl[7]  = '{2'b10, 16'h00FF, 16'h0000, 20, 16'hFF00, 16'd8};
    tbl[8]  = '{2'b10, 16'h00FF, 16'h0000, 20, 16'h00FF, 16'd9};
    tbl[9]  = '{2'b01, 16'h0000, 16'h4000,  9, 16'h4000, 16'd9};
    tbl[10] = '{2'b01, 16'h0000, 16'h4000, 20, 16'h4000, 16'd10};

    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b1;
    mode = 2'b00; const_data = 16'h0; ramp_step = 16'h0;
    model_reset();
    wclk(3);
    rst_n = 1'b1;
    wclk(1);
    chk("rst sdata", 32'(sdata), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    chk("rst err_short", 32'(err_short), 32'd0);
    chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
    wclk(H);

    for (int i = 0; i < 11; i++) begin
      frame(tbl[i].md, tbl[i].cd, tbl[i].st, tbl[i].nf, 1'b1, tbl[i].w, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d cnt const", i), 32'(frame_cnt), 32'(tbl[i].cnt));
    end

    // Reset in the middle of a frame, then cs_n held low must not start a frame.
    mode = 2'b01; ramp_step = 16'h1234; wclk(2);
    cs_n = 1'b0; wclk(H);
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b0; wclk(H);
      sclk = 1'b1; wclk(H);
    end
    rst_n = 1'b0; wclk(1);
    rst_n = 1'b1;
    model_reset();
    chk("mid rst sdata", 32'(sdata), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst frame_cnt", 32'(frame_cnt), 32'd0);
    begin
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      wclk(H);
      for (int i = 0; i < N; i++) begin
        sclk = 1'b0; wclk(H);
        sclk = 1'b1; wclk(H);
      end
      chk("held low no done", 32'(done_cnt - d0), 32'd0);
      chk("held low busy", 32'(busy), 32'd0);
      chk("held low sdata", 32'(sdata), 32'd0);
      cs_n = 1'b1; wclk(H);
      chk("held low no err", 32'(err_cnt - e0), 32'd0);
    end
    frame(2'b01, 16'h0, 16'h1234, N, 1'b1, 16'h0000, "post rst");
    frame(2'b01, 16'h0, 16'h1234, N, 1'b1, 16'h1234, "post rst2");

    for (int i = 0; i < 25; i++) begin
      logic [1:0]  md;
      logic [15:0] cd, st;
      int          nf;
      md = 2'($urandom_range(0, 3));
      cd = 16'($urandom);
      st = 16'($urandom);
      nf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N - 1)) : N;
      frame(md, cd, st, nf, 1'b0, 16'h0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
